// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the access-legality helpers used at request decode.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_H, F3_HU: return off[0];
         F3_W:        return off != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

   // Unsigned widths only make sense for loads.
   function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
      case (funct3)
         F3_B, F3_H, F3_W: return 1'b0;
         F3_BU, F3_HU:     return we;
         default:          return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: merges store data into a memory word and
// extracts/extends load data from a memory word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] merged,
   output logic [31:0] extended
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? word[31:16] : word[15:0];
      extended = '0;
      case (funct3)
         F3_B:    extended = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   extended = {24'd0, byte_sel};
         F3_H:    extended = {{16{half_sel[15]}}, half_sel};
         F3_HU:   extended = {16'd0, half_sel};
         F3_W:    extended = word;
         default: extended = '0;
      endcase
   end

   // Each lane independently picks the old byte or the matching store byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic [7:0] lane_byte;

         always_comb begin
            lane_byte = word[8*gi +: 8];
            if (funct3 == F3_B && offset == LANE)
               lane_byte = wdata[7:0];
            else if (funct3 == F3_H && offset[1] == LANE[1])
               lane_byte = wdata[8*(gi%2) +: 8];
            else if (funct3 == F3_W)
               lane_byte = wdata[8*gi +: 8];
         end

         assign merged[8*gi +: 8] = lane_byte;
      end
   endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage in front of a word-only data memory: sub-word stores
// become read-modify-write, loads are extracted and extended.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   lsu_state_e        state_reg, state_next;
   logic [2:0]        funct3_reg;
   logic              we_reg;
   logic              err_reg;
   logic [1:0]        off_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [DATA_W-1:0] load_data_reg;
   logic [ADDR_W-1:0] mem_addr_reg;

   logic              accept;
   logic              req_err;
   logic [DATA_W-1:0] merged_word;
   logic [DATA_W-1:0] extended_word;

   assign accept  = req_valid && (state_reg == IDLE);
   assign req_err = is_illegal(req_funct3, req_we) || is_misaligned(req_funct3, req_addr[1:0]);

   lsu_lane_align u_lane_align (
      .word     (mem_rdata),
      .wdata    (wdata_reg),
      .offset   (off_reg),
      .funct3   (funct3_reg),
      .merged   (merged_word),
      .extended (extended_word)
   );

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      resp_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err)
                  state_next = RESP;
               else if (req_we && req_funct3 == F3_W)
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD: begin
            mem_read   = 1'b1;
            state_next = we_reg ? WR : RESP;
         end
         WR: begin
            mem_write  = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign resp_err   = resp_valid && err_reg;
   assign resp_rdata = (resp_valid && !we_reg && !err_reg) ? load_data_reg : '0;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         funct3_reg    <= '0;
         we_reg        <= 1'b0;
         err_reg       <= 1'b0;
         off_reg       <= '0;
         wdata_reg     <= '0;
         mem_wdata_reg <= '0;
         load_data_reg <= '0;
         mem_addr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            funct3_reg   <= req_funct3;
            we_reg       <= req_we;
            err_reg      <= req_err;
            off_reg      <= req_addr[1:0];
            wdata_reg    <= req_wdata;
            mem_addr_reg <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we && req_funct3 == F3_W && !req_err)
               mem_wdata_reg <= req_wdata;
         end
         // The read word is consumed here: extended for loads, merged for RMW stores.
         if (state_reg == RD) begin
            load_data_reg <= extended_word;
            if (we_reg)
               mem_wdata_reg <= merged_word;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for reset
// and back-to-back traffic, and random traffic against a reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(9), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Data memory environment with a bench-side preload port.
   logic [31:0] mem [128];
   logic        pl_en;
   logic [6:0]  pl_idx;
   logic [31:0] pl_data;

   assign mem_rdata = mem[mem_addr[8:2]];

   always @(posedge clk) begin
      if (mem_write)
         mem[mem_addr[8:2]] <= mem_wdata;
      else if (pl_en)
         mem[pl_idx] <= pl_data;
   end

   int both_cnt = 0;
   always @(negedge clk)
      if (mem_read && mem_write) both_cnt++;

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] ref_mem [128];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_idx  = 7'(idx);
      pl_data = d;
      ref_mem[idx] = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Reference model: access rules expressed as byte arithmetic on a word array.
   function automatic void model(input bit we, input logic [2:0] f3, input logic [8:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit e,
                                 output int lat, output int nrd, output int nwr,
                                 output logic [31:0] wword);
      int size;
      int sh;
      logic [31:0] mask;
      logic [31:0] word;
      logic [31:0] v;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      if (size == 0) e = 1;
      else e = (we && f3[2]) || ((int'(a) % size) != 0);
      rd = 0; wword = 0; nrd = 0; nwr = 0; lat = 1;
      if (e) return;
      word = ref_mem[int'(a) / 4];
      sh   = 8 * (int'(a) % 4);
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (!we) begin
         v = (word >> sh) & mask;
         if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
         rd = v; lat = 2; nrd = 1;
      end else begin
         wword = (word & ~(mask << sh)) | ((wd & mask) << sh);
         ref_mem[int'(a) / 4] = wword;
         nwr = 1;
         if (size == 4) lat = 2;
         else begin lat = 3; nrd = 1; end
      end
   endfunction

   // One transaction; latency counts edges from the acceptance edge inclusive.
   task automatic run_req(input bit we, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat, output int nrd, output int nwr,
                          output logic [31:0] wword);
      bit done;
      int w;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      if (!req_ready) begin
         vectors++; miscompares++;
         $display("FAIL ready_timeout: req_ready still 0 after %0d cycles, required 1", w);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1; nrd = 0; nwr = 0; rd = 'x; e = 1'bx; wword = 0; done = 0;
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         if (resp_valid) begin
            rd = resp_rdata; e = resp_err; done = 1;
            break;
         end
         if (mem_read) nrd++;
         if (mem_write) begin nwr++; wword = mem_wdata; end
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL resp_timeout: no resp_valid within %0d edges, required 1 pulse", lat);
      end
      $display("txn we=%0d f3=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d lat=%0d rd=%0d wr=%0d",
               we, f3, a, wd, rd, e, lat, nrd, nwr);
   endtask

   typedef struct {
      bit          we;
      logic [2:0]  f3;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          exp_err;
      int          exp_lat;
      int          exp_nrd;
      int          exp_nwr;
   } vec_t;

   vec_t tbl [16];

   logic [31:0] bb_resp [4];
   bit          bb_we    [3];
   logic [31:0] bb_wd    [3];

   initial begin
      logic [31:0] rd, m_rd, m_ww, ww;
      logic        e;
      bit          m_e;
      int          lat, nrd, nwr, m_lat, m_nrd, m_nwr;

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;

      for (int i = 0; i < 128; i++) preload(i, $urandom);
      preload(8, 32'h8877_66F5);
      preload(9, 32'h1122_3344);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_req_ready",  32'(req_ready),  32'd1);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_resp_err",   32'(resp_err),   32'd0);
      check("reset_resp_rdata", resp_rdata,      32'd0);
      check("reset_mem_read",   32'(mem_read),   32'd0);
      check("reset_mem_write",  32'(mem_write),  32'd0);
      check("reset_mem_addr",   32'(mem_addr),   32'd0);
      check("reset_mem_wdata",  mem_wdata,       32'd0);

      //           we  f3    addr    wdata          rdata          err lat rd wr
      tbl[0]  = '{0, 3'd2, 9'h020, 32'h0,         32'h8877_66F5, 0, 2, 1, 0};
      tbl[1]  = '{0, 3'd0, 9'h020, 32'h0,         32'hFFFF_FFF5, 0, 2, 1, 0};
      tbl[2]  = '{0, 3'd4, 9'h020, 32'h0,         32'h0000_00F5, 0, 2, 1, 0};
      tbl[3]  = '{0, 3'd1, 9'h022, 32'h0,         32'hFFFF_8877, 0, 2, 1, 0};
      tbl[4]  = '{0, 3'd5, 9'h022, 32'h0,         32'h0000_8877, 0, 2, 1, 0};
      tbl[5]  = '{0, 3'd0, 9'h023, 32'h0,         32'hFFFF_FF88, 0, 2, 1, 0};
      tbl[6]  = '{0, 3'd1, 9'h023, 32'h0,         32'h0,         1, 1, 0, 0};
      tbl[7]  = '{1, 3'd2, 9'h022, 32'h1234_5678, 32'h0,         1, 1, 0, 0};
      tbl[8]  = '{0, 3'd3, 9'h020, 32'h0,         32'h0,         1, 1, 0, 0};
      tbl[9]  = '{1, 3'd4, 9'h020, 32'h55,        32'h0,         1, 1, 0, 0};
      tbl[10] = '{0, 3'd2, 9'h020, 32'h0,         32'h8877_66F5, 0, 2, 1, 0};
      tbl[11] = '{1, 3'd2, 9'h024, 32'hCAFE_BABE, 32'h0,         0, 2, 0, 1};
      tbl[12] = '{1, 3'd1, 9'h026, 32'h0000_1357, 32'h0,         0, 3, 1, 1};
      tbl[13] = '{0, 3'd2, 9'h024, 32'h0,         32'h1357_BABE, 0, 2, 1, 0};
      tbl[14] = '{1, 3'd0, 9'h025, 32'hFFFF_FF00, 32'h0,         0, 3, 1, 1};
      tbl[15] = '{0, 3'd2, 9'h024, 32'h0,         32'h1357_00BE, 0, 2, 1, 0};

      for (int i = 0; i < 16; i++) begin
         model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rd, m_e, m_lat, m_nrd, m_nwr, m_ww);
         run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, e, lat, nrd, nwr, ww);
         check("tbl_rdata",  rd,          tbl[i].exp_rd);
         check("tbl_err",    32'(e),      32'(tbl[i].exp_err));
         check("tbl_lat",    32'(lat),    32'(tbl[i].exp_lat));
         check("tbl_nread",  32'(nrd),    32'(tbl[i].exp_nrd));
         check("tbl_nwrite", 32'(nwr),    32'(tbl[i].exp_nwr));
      end
      check("err_mem_unchanged", mem[8], 32'h8877_66F5);

      // SB into the middle of a word: one read, one write with merged data.
      preload(8, 32'h1122_3344);
      run_req(1, 3'd0, 9'h021, 32'h0000_00AB, rd, e, lat, nrd, nwr, ww);
      void'(model(1, 3'd0, 9'h021, 32'h0000_00AB, m_rd, m_e, m_lat, m_nrd, m_nwr, m_ww));
      check("sb_nread",  32'(nrd), 32'd1);
      check("sb_nwrite", 32'(nwr), 32'd1);
      check("sb_wdata",  ww,       32'h1122_AB44);
      check("sb_lat",    32'(lat), 32'd3);
      run_req(0, 3'd2, 9'h020, 32'h0, rd, e, lat, nrd, nwr, ww);
      check("sb_readback", rd, 32'h1122_AB44);

      // Reset during the RD cycle of an SH drops the pending write.
      preload(10, 32'hCAFE_F00D);
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'd1; req_addr = 9'h02A; req_wdata = 32'h0000_BEEF; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rst_in_rd_mem_read", 32'(mem_read), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      nwr = 0; nrd = 0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         if (mem_write) nwr++;
         if (resp_valid) nrd++;
         @(negedge clk);
      end
      check("rst_no_write", 32'(nwr), 32'd0);
      check("rst_no_resp",  32'(nrd), 32'd0);
      check("rst_mem_kept", mem[10],  32'hCAFE_F00D);
      $display("txn reset-abort SH addr=02a -> writes=%0d resps=%0d", nwr, nrd);

      // Back-to-back LW / SW / LW with req_valid held high.
      preload(12, 32'h0102_0304);
      bb_we[0] = 0; bb_wd[0] = 32'h0;
      bb_we[1] = 1; bb_wd[1] = 32'hDEAD_BEEF;
      bb_we[2] = 0; bb_wd[2] = 32'h0;
      for (int j = 0; j < 3; j++)
         model(bb_we[j], 3'd2, 9'h030, bb_wd[j], m_rd, m_e, m_lat, m_nrd, m_nwr, m_ww);
      begin
         int acc, nresp;
         bit rdy;
         acc = 0; nresp = 0;
         @(negedge clk);
         req_we = bb_we[0]; req_funct3 = 3'd2; req_addr = 9'h030; req_wdata = bb_wd[0]; req_valid = 1'b1;
         for (int c = 0; c < 30; c++) begin
            rdy = req_ready;
            if (resp_valid) begin
               if (nresp < 4) bb_resp[nresp] = resp_rdata;
               nresp++;
            end
            @(posedge clk);
            if (req_valid && rdy) begin
               acc++;
               #1;
               if (acc < 3) begin req_we = bb_we[acc]; req_wdata = bb_wd[acc]; end
               else req_valid = 1'b0;
            end
            @(negedge clk);
         end
         req_valid = 1'b0;
         $display("txn back-to-back LW/SW/LW -> accepted=%0d responses=%0d", acc, nresp);
         check("b2b_accepts", 32'(acc),   32'd3);
         check("b2b_resps",   32'(nresp), 32'd3);
         check("b2b_resp0",   bb_resp[0], 32'h0102_0304);
         check("b2b_resp1",   bb_resp[1], 32'h0);
         check("b2b_resp2",   bb_resp[2], 32'hDEAD_BEEF);
      end

      // Random traffic against the reference model.
      for (int i = 0; i < 200; i++) begin
         bit          we;
         logic [2:0]  f3;
         logic [8:0]  a;
         logic [31:0] wd;
         we = bit'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) a = 9'h040 + 9'($urandom_range(0, 31));
         else a = 9'($urandom_range(0, 511));
         wd = $urandom;
         model(we, f3, a, wd, m_rd, m_e, m_lat, m_nrd, m_nwr, m_ww);
         run_req(we, f3, a, wd, rd, e, lat, nrd, nwr, ww);
         check("rnd_rdata",  rd,        m_rd);
         check("rnd_err",    32'(e),    32'(m_e));
         check("rnd_lat",    32'(lat),  32'(m_lat));
         check("rnd_nread",  32'(nrd),  32'(m_nrd));
         check("rnd_nwrite", 32'(nwr),  32'(m_nwr));
         if (m_nwr != 0) check("rnd_wword", ww, m_ww);
      end

      for (int i = 0; i < 128; i++)
         if (mem[i] !== ref_mem[i]) check("final_mem", mem[i], ref_mem[i]);
      check("rd_wr_overlap", 32'(both_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
